// File: rtl/ped_request_unit.sv
// ---------------------------------------------------------------------------
// ped_request_unit
//
// Purpose
//   Initiator side of the pedestrian crossing request interface. The raw,
//   bouncy push-button pin is synchronised and debounced. A rising edge of
//   the debounced level (a "press") raises a held request level towards the
//   pedestrian traffic light controller. The request stays up until the
//   controller answers with ped_green. The block also drives the "WAIT"
//   indicator, counts accepted presses and flags a controller that never
//   serves a request.
//
// Parameters
//   DEB_CYCLES   consecutive stable synchronised samples needed before the
//                debounced level follows the pin (>= 1)
//   REQ_TIMEOUT  cycles spent waiting in REQ without ped_green before the
//                FAULT state is entered (>= 2)
//   The simulation-only propagation delay (TP) of the original interface
//   is intentionally not modelled. Registered assignments carry no delay.
//
// Ports
//   i_clk         system clock, shared with the traffic light controller
//   i_rst         synchronous, active-high reset
//   i_btn_raw     raw push-button pin (asynchronous, bouncy, active-high)
//   i_ped_green   pedestrian green lamp, used as the acknowledge
//   i_ped_red     pedestrian red lamp, only checked with PED_LAMP_CHECK_EN
//   o_btn         request level, high in REQ and FAULT
//   o_wait_led    "WAIT" indicator, high in REQ and FAULT
//   o_req_fault   high while in FAULT
//   o_press_cnt   accepted presses, saturating at 255
//   o_lamp_err    sticky lamp-consistency error (PED_LAMP_CHECK_EN only)
//
// Configuration
//   PED_LAMP_CHECK_EN  when defined, adds o_lamp_err. o_lamp_err is set
//                      (and stays set until reset) when ped_green and
//                      ped_red are equal, after a two-cycle mask that
//                      follows reset. When undefined, the port does not
//                      exist and ped_red is ignored.
// ---------------------------------------------------------------------------
module ped_request_unit #(
  parameter int DEB_CYCLES  = 4,
  parameter int REQ_TIMEOUT = 120
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_raw,
  input  logic       i_ped_green,
  input  logic       i_ped_red,
  output logic       o_btn,
  output logic       o_wait_led,
  output logic       o_req_fault,
  output logic [7:0] o_press_cnt
`ifdef PED_LAMP_CHECK_EN
  ,
  output logic       o_lamp_err
`endif
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int TMR_W = $clog2(REQ_TIMEOUT + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REQ_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WALK  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn_db;
  logic             r_btn_db_q;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             w_press;

  state_t           r_state;
  state_t           w_next_state;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_next_timer;
  logic [7:0]       r_press_cnt;
  logic [7:0]       w_next_press_cnt;
  logic             w_next_req;
  logic             r_btn;
  logic             r_wait_led;
  logic             r_req_fault;

  // Input path: a two-flop synchroniser followed by a debouncer. The
  // counter counts consecutive synchronised samples that disagree with the
  // debounced level. When DEB_CYCLES of them have been seen in a row, the
  // level flips. Any agreeing sample restarts the count, so a glitch
  // shorter than DEB_CYCLES samples is never accepted. r_btn_db_q remembers
  // the previous debounced level for the rising-edge detector.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
      r_deb_cnt  <= '0;
    end else begin
      r_sync1    <= i_btn_raw;
      r_sync2    <= r_sync1;
      r_btn_db_q <= r_btn_db;
      if (r_sync2 == r_btn_db) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_btn_db  <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
    end
  end

  // A press is the one-cycle rising edge of the debounced level. A button
  // that is still held when the FSM comes back to IDLE has no new edge, so
  // it is not counted again.
  assign w_press = r_btn_db & ~r_btn_db_q;

  // State register, together with the wait timer, the press counter and
  // the registered outputs. The outputs are decoded from the next state,
  // so they change on the same edge as the state and never glitch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_press_cnt <= 8'd0;
      r_btn       <= 1'b0;
      r_wait_led  <= 1'b0;
      r_req_fault <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_timer     <= w_next_timer;
      r_press_cnt <= w_next_press_cnt;
      r_btn       <= w_next_req;
      r_wait_led  <= w_next_req;
      r_req_fault <= (w_next_state == ST_FAULT);
    end
  end

  // Next-state logic. A press in IDLE while pedestrians already have green
  // goes straight to WALK and is not counted. In REQ, ped_green wins over
  // the timeout, so an acknowledge on the last allowed cycle still counts
  // as served. The timer stops at REQ_TIMEOUT-1 and never wraps. Presses
  // outside IDLE are ignored.
  always_comb begin
    w_next_state     = r_state;
    w_next_timer     = r_timer;
    w_next_press_cnt = r_press_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          if (i_ped_green) begin
            w_next_state = ST_WALK;
          end else begin
            w_next_state = ST_REQ;
            w_next_timer = '0;
            if (r_press_cnt != 8'hFF) begin
              w_next_press_cnt = r_press_cnt + 8'd1;
            end
          end
        end
      end
      ST_REQ: begin
        if (i_ped_green) begin
          w_next_state = ST_WALK;
        end else if (r_timer == TMR_LAST) begin
          w_next_state = ST_FAULT;
        end else begin
          w_next_timer = r_timer + TMR_W'(1);
        end
      end
      ST_WALK: begin
        if (!i_ped_green) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (i_ped_green) begin
          w_next_state = ST_WALK;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    w_next_req = (w_next_state == ST_REQ) || (w_next_state == ST_FAULT);
  end

  assign o_btn       = r_btn;
  assign o_wait_led  = r_wait_led;
  assign o_req_fault = r_req_fault;
  assign o_press_cnt = r_press_cnt;

`ifdef PED_LAMP_CHECK_EN
  logic [1:0] r_lamp_mask;
  logic       r_lamp_err;

  // Lamp consistency monitor. Exactly one pedestrian lamp should be lit.
  // The first two cycles after reset are masked while the controller's
  // lamps settle. After that, any cycle with equal lamps sets the sticky
  // error, which only a reset clears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lamp_mask <= 2'd0;
      r_lamp_err  <= 1'b0;
    end else if (r_lamp_mask != 2'd2) begin
      r_lamp_mask <= r_lamp_mask + 2'd1;
    end else if (i_ped_green == i_ped_red) begin
      r_lamp_err <= 1'b1;
    end
  end

  assign o_lamp_err = r_lamp_err;
`else
  logic w_unused_ped_red;

  // Without the lamp check the red lamp input has no function.
  assign w_unused_ped_red = i_ped_red;
`endif

endmodule

// File: tb/tb_ped_request_unit.sv
// ---------------------------------------------------------------------------
// tb_ped_request_unit
//
// Purpose
//   Self-checking bench for ped_request_unit. A stimulus process drives the
//   pins once per cycle. A behavioural model predicts the outputs after
//   every clock edge and pushes them into a queue. A separate monitor pops
//   one entry per edge and compares it with the DUT.
//   Build with PED_LAMP_CHECK_EN defined to also exercise o_lamp_err.
// ---------------------------------------------------------------------------
module tb_ped_request_unit;

  localparam int DEB_CYCLES  = 4;
  localparam int REQ_TIMEOUT = 120;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnRaw;
  logic       pedGreen;
  logic       pedRed;
  logic       btn;
  logic       waitLed;
  logic       reqFault;
  logic [7:0] pressCnt;
`ifdef PED_LAMP_CHECK_EN
  logic       lampErr;
`endif

  typedef struct packed {
    logic       btn;
    logic       waitLed;
    logic       fault;
    logic [7:0] cnt;
    logic       lamp;
  } expect_t;

  expect_t expQ[$];
  int      checks = 0;
  int      errors = 0;

  // Model state. rawLog[e-1] holds the pin value sampled at edge e.
  bit rawLog[$];
  int edgeNo    = 0;
  int resetEdge = 0;
  bit mDb, mPressPending, mReqOpen, mFault, mWalking, mLamp;
  int mAge, mCount;

  ped_request_unit #(
    .DEB_CYCLES (DEB_CYCLES),
    .REQ_TIMEOUT(REQ_TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn_raw  (btnRaw),
    .i_ped_green(pedGreen),
    .i_ped_red  (pedRed),
    .o_btn      (btn),
    .o_wait_led (waitLed),
    .o_req_fault(reqFault),
    .o_press_cnt(pressCnt)
`ifdef PED_LAMP_CHECK_EN
    ,
    .o_lamp_err (lampErr)
`endif
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // The debouncer sees the pin two edges late, because of the
  // synchroniser. Anything sampled at or before the last reset edge reads
  // as 0.
  function automatic bit sampleAt(int j);
    if (j - 2 > resetEdge) return rawLog[j - 3];
    return 1'b0;
  endfunction

  // Behavioural model of one clock edge. The request lifecycle is tracked
  // with a few flags and a waited-cycles age. The debounced level flips
  // once the last DEB_CYCLES synchronised samples all disagree with it.
  task automatic modelEdge(input bit r, input bit raw, input bit pg, input bit pr);
    bit      allDiffer;
    expect_t e;
    edgeNo++;
    rawLog.push_back(raw);
    if (r) begin
      resetEdge     = edgeNo;
      mDb           = 0;
      mPressPending = 0;
      mReqOpen      = 0;
      mFault        = 0;
      mWalking      = 0;
      mLamp         = 0;
      mAge          = 0;
      mCount        = 0;
    end else begin
      if (mWalking) begin
        if (!pg) mWalking = 0;
      end else if (mReqOpen) begin
        if (pg) begin
          mReqOpen = 0;
          mFault   = 0;
          mWalking = 1;
        end else if (!mFault) begin
          mAge++;
          if (mAge == REQ_TIMEOUT) mFault = 1;
        end
      end else if (mPressPending) begin
        if (pg) begin
          mWalking = 1;
        end else begin
          mReqOpen = 1;
          mAge     = 0;
          if (mCount < 255) mCount++;
        end
      end
      allDiffer = 1;
      for (int j = edgeNo - DEB_CYCLES + 1; j <= edgeNo; j++)
        if (sampleAt(j) == mDb) allDiffer = 0;
      mPressPending = 0;
      if (allDiffer) begin
        mPressPending = !mDb;
        mDb           = !mDb;
      end
      if (edgeNo >= resetEdge + 3 && pg == pr) mLamp = 1;
    end
    e.btn     = mReqOpen;
    e.waitLed = mReqOpen;
    e.fault   = mFault;
    e.cnt     = 8'(mCount);
    e.lamp    = mLamp;
    expQ.push_back(e);
  endtask

  // Drive one cycle of pins away from the active edge, then let the model
  // predict the outputs that follow the next rising edge.
  task automatic applyStimulus(input bit r, input bit raw, input bit pg, input bit pr);
    @(negedge clk);
    rst      = r;
    btnRaw   = raw;
    pedGreen = pg;
    pedRed   = pr;
    @(posedge clk);
    modelEdge(r, raw, pg, pr);
  endtask

  task automatic step(input bit raw, input bit pg);
    applyStimulus(1'b0, raw, pg, !pg);
  endtask

  // Compare one predicted output set with the DUT.
  task automatic checkOutput(input expect_t e);
    bit bad;
    checks++;
    bad = (btn !== e.btn) || (waitLed !== e.waitLed) ||
          (reqFault !== e.fault) || (pressCnt !== e.cnt);
`ifdef PED_LAMP_CHECK_EN
    bad = bad || (lampErr !== e.lamp);
`endif
    if (bad) begin
      errors++;
      $display("[TB] FAIL outputs t=%0t: got btn=%b wait=%b fault=%b cnt=%0d, expected btn=%b wait=%b fault=%b cnt=%0d lamp=%b",
               $time, btn, waitLed, reqFault, pressCnt,
               e.btn, e.waitLed, e.fault, e.cnt, e.lamp);
    end
  endtask

  // Monitor: once the outputs have settled after each rising edge, check
  // them against the oldest pending prediction.
  always begin
    @(posedge clk);
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  // Hold the button until the model has accepted a request. Give up after
  // a bounded number of cycles.
  task automatic pressAndWait();
    int guard = 0;
    while (!mReqOpen && guard < 40) begin
      step(1'b1, 1'b0);
      guard++;
    end
    if (!mReqOpen) begin
      errors++;
      $display("[TB] FAIL press-accept: got no request within %0d cycles, expected one", guard);
    end
  endtask

  // Serve any open request, return to IDLE and let the debouncer settle low.
  task automatic settleIdle();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);
  endtask

  // Watchdog so that the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of run by t=%0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst      = 1'b1;
    btnRaw   = 1'b0;
    pedGreen = 1'b0;
    pedRed   = 1'b1;

    $display("[TB] reset for two cycles");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);

    $display("[TB] held press, latency and service");
    repeat (10) step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    settleIdle();

    $display("[TB] short glitches");
    for (int len = 1; len <= 3; len++) begin
      repeat (3) begin
        repeat (len) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
      end
    end

    $display("[TB] acknowledge on the timeout cycle");
    pressAndWait();
    guard = 0;
    while (mAge < REQ_TIMEOUT - 1 && guard < 200) begin
      step(1'b0, 1'b0);
      guard++;
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);

    $display("[TB] unserved request enters fault");
    pressAndWait();
    repeat (REQ_TIMEOUT + 10) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);

    $display("[TB] press while ped_green is already on");
    repeat (8) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b0);

    $display("[TB] reset in the middle of a request");
    pressAndWait();
    repeat (5) step(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);

    $display("[TB] randomized pin and lamp activity");
    repeat (300) begin
      bit rawV;
      bit pgV;
      int len;
      rawV = 1'($urandom % 2);
      pgV  = ($urandom_range(0, 3) == 0);
      len  = $urandom_range(1, 8);
      repeat (len) step(rawV, pgV);
    end
    settleIdle();

    $display("[TB] 256 served presses, counter saturation");
    repeat (256) begin
      pressAndWait();
      settleIdle();
    end

`ifdef PED_LAMP_CHECK_EN
    $display("[TB] lamp consistency error");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0);
`endif

    repeat (3) step(1'b0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
